// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-field helpers for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_OUT_WAIT,
        S_HALT
    } state_e;

    // Class is ir[7] for ALU, ir[7:6] for LDI, ir[7:4] for the rest.
    localparam logic       CLS_ALU = 1'b0;
    localparam logic [1:0] CLS_LDI = 2'b10;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int IR_OP_LO     = 4;
    localparam int IR_RD_LO     = 2;
    localparam int IR_RS_LO     = 0;
    localparam int IR_LDI_RD_LO = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    function automatic logic [2:0] ir_op(input logic [7:0] ir);
        return ir[IR_OP_LO +: 3];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [7:0] ir);
        return ir[IR_RD_LO +: 2];
    endfunction

    function automatic logic [1:0] ir_rs(input logic [7:0] ir);
        return ir[IR_RS_LO +: 2];
    endfunction

    function automatic logic [1:0] ir_ldi_rd(input logic [7:0] ir);
        return ir[IR_LDI_RD_LO +: 2];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-memory read port and output-byte port of the ALU sequencer.
interface alu_sequencer_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output imem_req, imem_addr, out_data, out_valid,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_data, out_valid,
        output imem_ack, imem_rdata, out_ready
    );
endinterface

// File: rtl/seq_regfile.sv
// 4x8 register file: two combinational reads, one synchronous write, async clear.
module seq_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);
    logic [3:0][7:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control for the 8-bit ALU datapath.
// Define ALU_SEQ_STEP_EN to add a step input that gates each opcode fetch.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_STEP_EN
    input  logic             step,
`endif
    alu_sequencer_if.master  bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_s,
    input  logic             alu_c,
    output logic             carry,
    output logic             halted
);
    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       carry_q, carry_d;
    logic       req_q, req_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       halted_q, halted_d;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       ack;
    logic       fetch_ok;

    assign ack = req_q & bus.imem_ack;

`ifdef ALU_SEQ_STEP_EN
    logic step_pend_q, step_pend_d;

    // A step seen now counts immediately; it is consumed by the opcode-fetch ack.
    assign fetch_ok = step_pend_q | step;

    always_comb begin
        step_pend_d = (step_pend_q | step) & ~(state_q == S_FETCH && ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_pend_q <= 1'b0;
        else        step_pend_q <= step_pend_d;
    end
`else
    assign fetch_ok = 1'b1;
`endif

    seq_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir_rd(ir_q)),
        .raddr_b (ir_rs(ir_q)),
        .rdata_a (alu_a),
        .rdata_b (alu_b)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        carry_d     = carry_q;
        req_d       = req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_waddr    = ir_rd(ir_q);
        rf_wdata    = alu_s;

        case (state_q)
            S_FETCH: begin
                if (ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + 8'd1;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end else if (!req_q && fetch_ok) begin
                    req_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (ir_q[7] == CLS_ALU) begin
                    rf_we   = 1'b1;
                    carry_d = alu_c;
                    req_d   = fetch_ok;
                    state_d = S_FETCH;
                end else if (ir_q[7:6] == CLS_LDI) begin
                    req_d   = 1'b1;
                    state_d = S_FETCH_IMM;
                end else begin
                    case (ir_q[7:4])
                        OP_JMP, OP_JC: begin
                            req_d   = 1'b1;
                            state_d = S_FETCH_IMM;
                        end
                        OP_OUT: begin
                            out_valid_d = 1'b1;
                            out_data_d  = alu_b;
                            state_d     = S_OUT_WAIT;
                        end
                        default: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                    endcase
                end
            end
            S_FETCH_IMM: begin
                if (ack) begin
                    req_d   = fetch_ok;
                    state_d = S_FETCH;
                    if (ir_q[7:6] == CLS_LDI) begin
                        rf_we    = 1'b1;
                        rf_waddr = ir_ldi_rd(ir_q);
                        rf_wdata = bus.imem_rdata;
                        pc_d     = pc_q + 8'd1;
                    end else if (ir_q[7:4] == OP_JMP) begin
                        pc_d = bus.imem_rdata;
                    end else begin
                        pc_d = carry_q ? bus.imem_rdata : pc_q + 8'd1;
                    end
                end
            end
            S_OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    req_d       = fetch_ok;
                    state_d     = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            carry_q     <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            carry_q     <= carry_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign alu_op        = ir_op(ir_q);
    assign carry         = carry_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench: an ISA-level interpreter predicts fetch addresses and output bytes.
module tb_alu_sequencer;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       c;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_s;
    logic [2:0] alu_op;
    logic       alu_c, carry, halted;

    alu_sequencer_if bus_if ();

    alu_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_s  (alu_s),
        .alu_c  (alu_c),
        .carry  (carry),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] fq[$];
    out_t       oq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ack_wait = 0;   // <0 picks a random wait per read
    int         rdy_stall = 0;  // <0 drives out_ready randomly

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    assign {alu_c, alu_s} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder.
    int wcnt = 0;
    int cur_wait = 0;
    always @(negedge clk) begin
        if (!rst_n || !bus_if.imem_req) begin
            bus_if.imem_ack   = 1'b0;
            bus_if.imem_rdata = 8'h00;
            wcnt     = 0;
            cur_wait = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
        end else if (wcnt >= cur_wait) begin
            bus_if.imem_ack   = 1'b1;
            bus_if.imem_rdata = mem[bus_if.imem_addr];
            wcnt     = 0;
            cur_wait = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
        end else begin
            bus_if.imem_ack   = 1'b0;
            bus_if.imem_rdata = 8'($urandom);
            wcnt++;
        end
    end

    // Output consumer.
    int scnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !bus_if.out_valid) begin
            bus_if.out_ready = 1'b0;
            scnt = 0;
        end else if (rdy_stall < 0) begin
            bus_if.out_ready = 1'($urandom);
        end else if (scnt >= rdy_stall) begin
            bus_if.out_ready = 1'b1;
        end else begin
            bus_if.out_ready = 1'b0;
            scnt++;
        end
    end

    // Monitor: everything sampled here is stable until the next rising edge.
    logic       p_req = 1'b0, p_ack = 1'b0, p_val = 1'b0, p_rdy = 1'b0;
    logic [7:0] p_addr = '0, p_od = '0;
    always @(negedge clk) begin
        logic [7:0] ea;
        out_t       eo;
        #1;
        if (!rst_n) begin
            p_req = 1'b0;
            p_val = 1'b0;
        end else begin
            if (p_req && !p_ack) begin
                chk("req_hold", bus_if.imem_req, 1'b1);
                chk("addr_hold", bus_if.imem_addr, p_addr);
            end
            if (p_val && !p_rdy) begin
                chk("oval_hold", bus_if.out_valid, 1'b1);
                chk("odata_hold", bus_if.out_data, p_od);
                chk("no_fetch_in_out", bus_if.imem_req, 1'b0);
            end
            if (bus_if.imem_req && bus_if.imem_ack && fq.size() > 0) begin
                ea = fq.pop_front();
                chk("fetch_addr", bus_if.imem_addr, ea);
            end
            if (bus_if.out_valid && bus_if.out_ready && oq.size() > 0) begin
                eo = oq.pop_front();
                chk("out_data", bus_if.out_data, eo.data);
                chk("out_carry", carry, eo.c);
            end
            p_req  = bus_if.imem_req;
            p_ack  = bus_if.imem_ack;
            p_addr = bus_if.imem_addr;
            p_val  = bus_if.out_valid;
            p_rdy  = bus_if.out_ready;
            p_od   = bus_if.out_data;
        end
    end

    // Instruction-level interpreter of the program in mem.
    task automatic model(input int limit, output bit halts, output logic cf);
        logic [7:0] pc, ir, imm;
        logic [7:0] r [4];
        logic       c;
        logic [8:0] res;
        out_t       o;
        pc = RESET_PC;
        c = 1'b0;
        halts = 1'b0;
        foreach (r[i]) r[i] = 8'h00;
        for (int n = 0; n < limit && !halts; n++) begin
            ir = mem[pc];
            fq.push_back(pc);
            pc++;
            if (!ir[7]) begin
                res = alu_f(ir[6:4], r[ir[3:2]], r[ir[1:0]]);
                r[ir[3:2]] = res[7:0];
                c = res[8];
            end else if (ir[7:6] == 2'b10 || ir[7:5] == 3'b110) begin
                imm = mem[pc];
                fq.push_back(pc);
                if (!ir[6]) begin
                    r[ir[5:4]] = imm;
                    pc++;
                end else if (!ir[4]) begin
                    pc = imm;
                end else begin
                    pc = c ? imm : pc + 8'd1;
                end
            end else if (!ir[4]) begin
                o.data = r[ir[1:0]];
                o.c    = c;
                oq.push_back(o);
            end else begin
                halts = 1'b1;
            end
        end
        cf = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        oq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus_if.imem_req, 1'b0);
        chk("rst_addr", bus_if.imem_addr, RESET_PC);
        chk("rst_oval", bus_if.out_valid, 1'b0);
        chk("rst_odata", bus_if.out_data, 8'h00);
        chk("rst_carry", carry, 1'b0);
        chk("rst_halted", halted, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_rise", bus_if.imem_req, 1'b1);
        chk("first_addr", bus_if.imem_addr, RESET_PC);
    endtask

    task automatic run_prog(input int aw, input int rs, input int limit);
        bit   halts;
        logic cf;
        int   cyc;
        ack_wait  = aw;
        rdy_stall = rs;
        do_reset();
        model(limit, halts, cf);
        release_reset();
        cyc = 0;
        while ((fq.size() != 0 || oq.size() != 0) && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_in_time", cyc < 5000, 1'b1);
        if (halts) begin
            repeat (4) @(posedge clk);
            #1;
            chk("halted", halted, 1'b1);
            chk("halt_no_req", bus_if.imem_req, 1'b0);
            chk("final_carry", carry, cf);
        end
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic prog1();
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h90; mem[3] = 8'h03;
        mem[4] = 8'h01; mem[5] = 8'hE0; mem[6] = 8'hF0;
    endtask

    initial begin
        int cyc;
        // Basic add, output, halt.
        prog1();
        run_prog(0, 0, 64);

        // Carry out of add, taken JC.
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'hFF; mem[2] = 8'h90; mem[3] = 8'h01;
        mem[4] = 8'h01; mem[5] = 8'hD0; mem[6] = 8'h20;
        mem[8'h20] = 8'hE0; mem[8'h21] = 8'hF0;
        run_prog(0, 0, 64);

        // Borrow from sub, then carry cleared and JC falls through.
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h03; mem[2] = 8'h90; mem[3] = 8'h05;
        mem[4] = 8'h11; mem[5] = 8'hE0; mem[6] = 8'hA0; mem[7] = 8'h00;
        mem[8] = 8'h08; mem[9] = 8'hD0; mem[10] = 8'h40; mem[11] = 8'hE2;
        mem[12] = 8'hF0;
        run_prog(0, 0, 64);

        // Slow memory and slow consumer.
        prog1();
        run_prog(3, 0, 64);
        prog1();
        run_prog(0, 5, 64);

        // Immediate fetch across the 0xFF -> 0x00 wrap.
        clear_mem();
        mem[0] = 8'h5A; mem[1] = 8'hD0; mem[2] = 8'h30;
        mem[3] = 8'h80; mem[4] = 8'hFF; mem[5] = 8'h90; mem[6] = 8'h01;
        mem[7] = 8'h01; mem[8] = 8'hE2; mem[9] = 8'hC0; mem[10] = 8'hFF;
        mem[8'hFF] = 8'hA0; mem[8'h30] = 8'hE2; mem[8'h31] = 8'hF0;
        run_prog(0, 0, 64);

        // Reset while an output is stalled.
        prog1();
        ack_wait  = 0;
        rdy_stall = 100000;
        do_reset();
        release_reset();
        cyc = 0;
        while (!bus_if.out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_out_wait", bus_if.out_valid, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_oval", bus_if.out_valid, 1'b0);
        chk("async_addr", bus_if.imem_addr, RESET_PC);
        run_prog(0, 0, 64);

        // Random programs, random wait states and ready.
        for (int t = 0; t < 20; t++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            run_prog(-1, -1, 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that drives the 8-bit ALU. It fetches instruction bytes over a req/ack program-memory port and decodes them. It issues op and operands to the ALU and writes ALU results back into a 4x8 register file with a carry flag. It supports load-immediate, absolute and carry-conditional jumps, a handshaked output port, and halt. It is the instruction side of the CPU datapath.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  program-memory read request.
imem_addr  output  8  read address, equal to PC while imem_req=1.
imem_ack  input  1  read complete; imem_rdata valid this cycle.
imem_rdata  input  8  instruction/immediate byte.
alu_a  output  8  R[IR[3:2]].
alu_b  output  8  R[IR[1:0]].
alu_op  output  3  IR[6:4], using ALU encoding 000 add … 111 shr.
alu_s  input  8  ALU result.
alu_c  input  1  ALU carry/borrow (bit 8 of the 9-bit result).
out_data  output  8  output byte.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts.
carry  output  1  carry flag.
halted  output  1  HALT executed.

Behaviour:
- Encoding: 0ooo_ddss = ALU Rd<=Rd op Rs (1 byte); 10dd_xxxx = LDI Rd,imm8 (2 bytes); 1100_xxxx = JMP addr8; 1101_xxxx = JC addr8; 1110_xxss = OUT Rs; 1111_xxxx = HALT.
- States: FETCH, DECODE, FETCH_IMM, OUT_WAIT, HALT.
- Reset values (asynchronous): state=FETCH, PC=RESET_PC, IR=0, R0..R3=0, carry=0, imem_req=0, out_valid=0, out_data=0, halted=0. imem_req rises on the first clk edge after rst_n deasserts.
- FETCH: imem_req=1, imem_addr=PC. Both are held stable until imem_ack. On ack: IR<=imem_rdata, PC<=PC+1, go to DECODE. Ack in the same cycle req first rises is legal.
- DECODE (1 cycle):
  - ALU class: Rd<=alu_s, carry<=alu_c, go to FETCH.
  - LDI/JMP/JC: go to FETCH_IMM.
  - OUT: go to OUT_WAIT.
  - HALT: go to HALT.
- FETCH_IMM: same req/ack rules as FETCH. On ack:
  - LDI: Rd<=imem_rdata, PC<=PC+1.
  - JMP: PC<=imem_rdata.
  - JC: PC<=carry ? imem_rdata : PC+1.
  - Then go to FETCH.
- OUT_WAIT: out_valid=1, out_data=R[IR[1:0]], both stable until the out_valid&&out_ready edge. On that edge: out_valid<=0, go to FETCH. No fetch while waiting.
- HALT: halted=1, imem_req=0. Leave only by reset.
- Only ALU instructions write carry. LDI/JMP/JC/OUT leave it unchanged.
- PC is 8 bits and wraps 0xFF->0x00, including the immediate fetch for an instruction located at 0xFF.
- alu_a/alu_b/alu_op are combinational from IR and the register file in every state. They are consumed only in DECODE.
- ALU-instruction latency: 1 cycle fetch after ack plus 1 DECODE cycle, so the result is visible 2 edges after the instruction ack.

Optional Feature:
ALU_SEQ_STEP_EN: adds input port step (1 bit). FETCH does not assert imem_req until a cycle with step=1 has been seen; that pending step is cleared when the fetch ack is taken. FETCH_IMM is unaffected. Without the macro there is no step port and the block runs freely.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum;
  - opcode class constants (CLS_ALU, CLS_LDI, OP_JMP, OP_JC, OP_OUT, OP_HALT);
  - IR field bit positions;
  - ALU op codes 3'b000..3'b111.
- One sub-module, seq_regfile: 4x8, two combinational reads, one synchronous write, async clear.

Test Plan:
- Program 80 05 90 03 01 E0 F0, zero-wait ack -> out_data=0x08 with out_valid, carry=0, then halted=1 and imem_req=0.
- Program 80 FF 90 01 01 D0 20, with 0xE0 at 0x20 -> R0=0x00, carry=1, fetch at 0x20, output 0x00.
- Program 80 03 90 05 11 (sub R0,R1) -> R0=0xFE, carry=1; a following JC not-taken case with carry=0 falls through to PC+2.
- imem_ack delayed 3 cycles on every read -> imem_req/imem_addr stable throughout; same architectural results as the zero-wait case.
- OUT with out_ready low 5 cycles -> out_valid/out_data held, no imem_req; complete on the ready cycle.
- JMP FF, with LDI R2 at 0xFF and imm 0x5A at 0x00 -> R2=0x5A, next fetch addr 0x01. Assert rst_n=0 mid OUT_WAIT -> out_valid drops immediately, restart fetch at RESET_PC.
